// File: rtl/fifo_stream_writer.sv
// fifo_stream_writer
// Write-domain ingress adapter in front of afifo. A two-entry skid buffer
// (head/tail) decouples the upstream valid/ready handshake from the FIFO full
// flag, so ing_ready comes straight from the state register and egr_full only
// reaches egr_write_en combinationally.
//
// Optional build macro: FIFO_STREAM_WRITER_STATS_EN
//   adds sr_clear, sr_accepted_count and sr_stall_count (wrapping counters).
//
// state    | meaning
// ---------+---------------------------------------------
// ST_EMPTY | no word held
// ST_ONE   | one word held, in head
// ST_TWO   | two words held, head older than tail

module fifo_stream_writer #(
   parameter int DATA_WIDTH_P = -1,
   parameter int CNT_WIDTH_P  = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ing_valid,
   output logic                    ing_ready,
   input  logic [DATA_WIDTH_P-1:0] ing_data,
   output logic                    egr_write_en,
   output logic [DATA_WIDTH_P-1:0] egr_data,
   input  logic                    egr_full
`ifdef FIFO_STREAM_WRITER_STATS_EN
   ,
   input  logic                    sr_clear,
   output logic [CNT_WIDTH_P-1:0]  sr_accepted_count,
   output logic [CNT_WIDTH_P-1:0]  sr_stall_count
`endif
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [DATA_WIDTH_P-1:0] head;
   logic [DATA_WIDTH_P-1:0] tail;
   logic                    in_xfer;
   logic                    out_xfer;

   assign in_xfer  = ing_valid && ing_ready;
   assign out_xfer = egr_write_en;
   assign egr_data = head;

   // occupancy state register; reset drops any buffered words
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   // occupancy next-state from accept/write transfers
   always_comb begin
      state_nxt = state;
      case (state)
         ST_EMPTY: begin
            if (in_xfer) begin
               state_nxt = ST_ONE;
            end
         end
         ST_ONE: begin
            if (in_xfer && !out_xfer) begin
               state_nxt = ST_TWO;
            end else if (!in_xfer && out_xfer) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_TWO: begin
            // ing_ready is low here, so only a drain can happen
            if (out_xfer) begin
               state_nxt = ST_ONE;
            end
         end
         default: begin
            state_nxt = ST_EMPTY;
         end
      endcase
   end

   // handshake outputs; ing_ready depends on the state register only
   always_comb begin
      ing_ready    = 1'b1;
      egr_write_en = 1'b0;
      case (state)
         ST_EMPTY: begin
            ing_ready    = 1'b1;
            egr_write_en = 1'b0;
         end
         ST_ONE: begin
            ing_ready    = 1'b1;
            egr_write_en = !egr_full;
         end
         ST_TWO: begin
            ing_ready    = 1'b0;
            egr_write_en = !egr_full;
         end
         default: begin
            ing_ready    = 1'b0;
            egr_write_en = 1'b0;
         end
      endcase
   end

   // skid storage; left unreset since state alone qualifies its contents
   always_ff @(posedge clk) begin
      case (state)
         ST_EMPTY: begin
            if (in_xfer) begin
               head <= ing_data;
            end
         end
         ST_ONE: begin
            if (in_xfer && out_xfer) begin
               head <= ing_data;
            end else if (in_xfer) begin
               tail <= ing_data;
            end
         end
         ST_TWO: begin
            if (out_xfer) begin
               head <= tail;
            end
         end
         default: begin
            head <= head;
         end
      endcase
   end

`ifdef FIFO_STREAM_WRITER_STATS_EN
   logic stall_cycle;

   assign stall_cycle = (state != ST_EMPTY) && egr_full;

   // statistics counters; clear wins over a same-cycle increment
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sr_accepted_count <= '0;
         sr_stall_count    <= '0;
      end else if (sr_clear) begin
         sr_accepted_count <= '0;
         sr_stall_count    <= '0;
      end else begin
         if (out_xfer) begin
            sr_accepted_count <= sr_accepted_count + 1'b1;
         end
         if (stall_cycle) begin
            sr_stall_count <= sr_stall_count + 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fifo_stream_writer.sv
// Directed bench for fifo_stream_writer: reset, streaming, backpressure,
// toggling full, reset in TWO, random source/sink, and (with the stats macro)
// counter wrap and clear.

module tb_fifo_stream_writer;

   localparam int DW  = 8;
   localparam int CNT = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          ing_valid;
   logic          ing_ready;
   logic [DW-1:0] ing_data;
   logic          egr_write_en;
   logic [DW-1:0] egr_data;
   logic          egr_full;
`ifdef FIFO_STREAM_WRITER_STATS_EN
   logic           sr_clear;
   logic [CNT-1:0] sr_accepted_count;
   logic [CNT-1:0] sr_stall_count;
`endif

   int errors = 0;
   int checks = 0;
   logic [DW-1:0] sb_q[$];

   always #5 clk = ~clk;

   fifo_stream_writer #(
      .DATA_WIDTH_P (DW),
      .CNT_WIDTH_P  (CNT)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .ing_valid    (ing_valid),
      .ing_ready    (ing_ready),
      .ing_data     (ing_data),
      .egr_write_en (egr_write_en),
      .egr_data     (egr_data),
      .egr_full     (egr_full)
`ifdef FIFO_STREAM_WRITER_STATS_EN
      ,
      .sr_clear          (sr_clear),
      .sr_accepted_count (sr_accepted_count),
      .sr_stall_count    (sr_stall_count)
`endif
   );

`ifdef FIFO_STREAM_WRITER_STATS_EN
   task automatic clear_stats();
      @(negedge clk);
      ing_valid = 1'b0;
      egr_full  = 1'b0;
      sr_clear  = 1'b1;
      @(negedge clk);
      sr_clear  = 1'b0;
   endtask
`endif

   task automatic test_reset();
      rst_n     = 1'b0;
      ing_valid = 1'b0;
      ing_data  = '0;
      egr_full  = 1'b0;
`ifdef FIFO_STREAM_WRITER_STATS_EN
      sr_clear  = 1'b0;
`endif
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (ing_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ing_ready got=%b exp=1", ing_ready);
      end
      checks++;
      if (egr_write_en !== 1'b0) begin
         errors++;
         $display("FAIL reset_write_en got=%b exp=0", egr_write_en);
      end
`ifdef FIFO_STREAM_WRITER_STATS_EN
      checks++;
      if (sr_accepted_count !== '0 || sr_stall_count !== '0) begin
         errors++;
         $display("FAIL reset_counters got=%0d/%0d exp=0/0", sr_accepted_count, sr_stall_count);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_streaming();
`ifdef FIFO_STREAM_WRITER_STATS_EN
      clear_stats();
`endif
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         egr_full  = 1'b0;
         ing_valid = (i < 16);
         ing_data  = DW'(i + 1);
         #1;
         checks++;
         if (egr_write_en !== (i >= 1 && i <= 16)) begin
            errors++;
            $display("FAIL stream_write_en cyc=%0d got=%b exp=%b", i, egr_write_en, (i >= 1 && i <= 16));
         end
         if (i >= 1 && i <= 16) begin
            checks++;
            if (egr_data !== DW'(i)) begin
               errors++;
               $display("FAIL stream_data cyc=%0d got=%h exp=%h", i, egr_data, DW'(i));
            end
         end
         checks++;
         if (ing_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready cyc=%0d got=%b exp=1", i, ing_ready);
         end
      end
      ing_valid = 1'b0;
`ifdef FIFO_STREAM_WRITER_STATS_EN
      @(negedge clk);
      checks++;
      if (sr_accepted_count !== CNT'(16 % (1 << CNT))) begin
         errors++;
         $display("FAIL stream_accept_cnt got=%0d exp=%0d", sr_accepted_count, 16 % (1 << CNT));
      end
`endif
   endtask

   task automatic test_backpressure();
      logic [DW-1:0] din [8]  = '{8'hA1, 8'hA2, 8'hA3, 8'hA3, 8'hA3, 8'hA3, 8'h00, 8'h00};
      logic          vin [8]  = '{1, 1, 1, 1, 1, 1, 0, 0};
      logic          fin [8]  = '{1, 1, 1, 1, 0, 0, 0, 0};
      logic          rdy [8]  = '{1, 1, 0, 0, 0, 1, 1, 1};
      logic          wen [8]  = '{0, 0, 0, 0, 1, 1, 1, 0};
      logic [DW-1:0] dexp [8] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'h00};
`ifdef FIFO_STREAM_WRITER_STATS_EN
      clear_stats();
`endif
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         ing_valid = vin[i];
         ing_data  = din[i];
         egr_full  = fin[i];
         #1;
         checks++;
         if (ing_ready !== rdy[i]) begin
            errors++;
            $display("FAIL bp_ready cyc=%0d got=%b exp=%b", i, ing_ready, rdy[i]);
         end
         checks++;
         if (egr_write_en !== wen[i]) begin
            errors++;
            $display("FAIL bp_write_en cyc=%0d got=%b exp=%b", i, egr_write_en, wen[i]);
         end
         if (wen[i]) begin
            checks++;
            if (egr_data !== dexp[i]) begin
               errors++;
               $display("FAIL bp_data cyc=%0d got=%h exp=%h", i, egr_data, dexp[i]);
            end
         end
      end
      ing_valid = 1'b0;
`ifdef FIFO_STREAM_WRITER_STATS_EN
      @(negedge clk);
      checks++;
      if (sr_stall_count !== CNT'(3)) begin
         errors++;
         $display("FAIL bp_stall_cnt got=%0d exp=3", sr_stall_count);
      end
      checks++;
      if (sr_accepted_count !== CNT'(3)) begin
         errors++;
         $display("FAIL bp_accept_cnt got=%0d exp=3", sr_accepted_count);
      end
`endif
   endtask

   task automatic test_toggle_full();
      int sent = 0;
      int low_run = 0;
      int cyc = 0;
      logic full_t = 1'b0;
      sb_q.delete();
      while ((sent < 100 || sb_q.size() != 0) && cyc < 1000) begin
         @(negedge clk);
         ing_valid = (sent < 100);
         ing_data  = DW'($urandom_range(0, 255));
         egr_full  = (sent < 100) ? full_t : 1'b0;
         full_t    = ~full_t;
         #1;
         low_run = ing_ready ? 0 : low_run + 1;
         checks++;
         if (low_run > 1) begin
            errors++;
            $display("FAIL toggle_ready_low cyc=%0d got=%0d exp<=1", cyc, low_run);
         end
         if (egr_write_en) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL toggle_dup cyc=%0d got=%h exp=none", cyc, egr_data);
            end else begin
               if (egr_data !== sb_q[0]) begin
                  errors++;
                  $display("FAIL toggle_order cyc=%0d got=%h exp=%h", cyc, egr_data, sb_q[0]);
               end
               void'(sb_q.pop_front());
            end
         end
         if (ing_valid && ing_ready) begin
            sb_q.push_back(ing_data);
            sent++;
         end
         cyc++;
      end
      ing_valid = 1'b0;
      checks++;
      if (sb_q.size() != 0 || sent != 100) begin
         errors++;
         $display("FAIL toggle_complete got=%0d left/%0d sent exp=0/100", sb_q.size(), sent);
      end
   endtask

   task automatic test_reset_mid();
      logic [DW-1:0] d2 [2] = '{8'h55, 8'h66};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         ing_valid = 1'b1;
         ing_data  = d2[i];
         egr_full  = 1'b1;
      end
      @(negedge clk);
      ing_valid = 1'b0;
      #1;
      checks++;
      if (ing_ready !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_in_two got=%b exp=0", ing_ready);
      end
      egr_full = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (egr_write_en !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_write_en got=%b exp=0", egr_write_en);
      end
      checks++;
      if (ing_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_ready got=%b exp=1", ing_ready);
      end
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if (egr_write_en !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_stale_write cyc=%0d got=%b data=%h exp=0", i, egr_write_en, egr_data);
         end
      end
      sb_q.delete();
   endtask

   task automatic test_random();
      int acc = 0;
      int wr = 0;
      sb_q.delete();
      for (int cyc = 0; cyc < 10200; cyc++) begin
         @(negedge clk);
         ing_valid = (cyc < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
         ing_data  = DW'($urandom_range(0, 255));
         egr_full  = (cyc < 10000) ? ($urandom_range(0, 2) == 0) : 1'b0;
         #1;
         if (egr_full) begin
            checks++;
            if (egr_write_en !== 1'b0) begin
               errors++;
               $display("FAIL rand_write_while_full cyc=%0d got=%b exp=0", cyc, egr_write_en);
            end
         end
         if (egr_write_en) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++;
               $display("FAIL rand_dup cyc=%0d got=%h exp=none", cyc, egr_data);
            end else begin
               if (egr_data !== sb_q[0]) begin
                  errors++;
                  $display("FAIL rand_order cyc=%0d got=%h exp=%h", cyc, egr_data, sb_q[0]);
               end
               void'(sb_q.pop_front());
            end
            wr++;
         end
         if (ing_valid && ing_ready) begin
            sb_q.push_back(ing_data);
            acc++;
         end
      end
      ing_valid = 1'b0;
      checks++;
      if (sb_q.size() != 0 || acc != wr || acc == 0) begin
         errors++;
         $display("FAIL rand_drain got=%0d accepted %0d written exp equal and nonzero", acc, wr);
      end
   endtask

`ifdef FIFO_STREAM_WRITER_STATS_EN
   task automatic test_counter_wrap();
      clear_stats();
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         ing_valid = (i < 17);
         ing_data  = DW'(i);
         egr_full  = 1'b0;
      end
      @(negedge clk);
      ing_valid = 1'b0;
      #1;
      checks++;
      if (sr_accepted_count !== CNT'(1)) begin
         errors++;
         $display("FAIL wrap_accept_cnt got=%0d exp=1", sr_accepted_count);
      end
      ing_valid = 1'b1;
      ing_data  = 8'h3C;
      @(negedge clk);
      ing_valid = 1'b0;
      sr_clear  = 1'b1;
      #1;
      checks++;
      if (egr_write_en !== 1'b1) begin
         errors++;
         $display("FAIL clear_cycle_write got=%b exp=1", egr_write_en);
      end
      @(negedge clk);
      sr_clear = 1'b0;
      #1;
      checks++;
      if (sr_accepted_count !== CNT'(0)) begin
         errors++;
         $display("FAIL clear_priority got=%0d exp=0", sr_accepted_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_toggle_full();
      test_reset_mid();
      test_random();
`ifdef FIFO_STREAM_WRITER_STATS_EN
      test_counter_wrap();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
